// File: rtl/multicycle_controller.sv
// Main control FSM for the RISC-V multicycle core: fetch/decode/execute/memory/writeback sequencing.
// Optional: define MC_BNE_EN to accept bne (branch funct3=001) in addition to beq.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state, nxt;

  // registered Moore flags; the input-qualified strobes are gated below
  logic       fetch_q, memw_q, br_q, pcw_q, regw_q, done_q, funct_q, execr_q, halt_q;
  logic       adr_q;
  logic [1:0] res_q, a_q, b_q;
  logic [2:0] alu_q;

  logic       br_ok, taken;
  logic [2:0] funct_alu;

`ifdef MC_BNE_EN
  assign br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign taken = funct3[0] ? ~zero : zero;
`else
  assign br_ok = (funct3 == 3'b000);
  assign taken = zero;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt = S_MEMADR;
          OP_RTYPE:          nxt = S_EXECR;
          OP_ITYPE:          nxt = S_EXECI;
          OP_BRANCH:         nxt = br_ok ? S_BEQ : S_HALT;
          OP_JAL:            nxt = S_JAL;
          default:           nxt = S_HALT;
        endcase
      end
      S_MEMADR:   nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    nxt = S_FETCH;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    nxt = S_ALUWB;
      S_EXECI:    nxt = S_ALUWB;
      S_ALUWB:    nxt = S_FETCH;
      S_BEQ:      nxt = S_FETCH;
      S_JAL:      nxt = S_ALUWB;
      S_HALT:     nxt = S_HALT;
      default:    nxt = S_HALT;
    endcase
  end

  // funct3 comes from the IR, which is stable outside FETCH
  always_comb begin
    funct_alu = ALU_ADD;
    case (funct3)
      3'b000:  funct_alu = (execr_q && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      fetch_q <= 1'b1;
      memw_q  <= 1'b0;
      br_q    <= 1'b0;
      pcw_q   <= 1'b0;
      regw_q  <= 1'b0;
      done_q  <= 1'b0;
      funct_q <= 1'b0;
      execr_q <= 1'b0;
      halt_q  <= 1'b0;
      adr_q   <= 1'b0;
      res_q   <= 2'b10;
      a_q     <= 2'b00;
      b_q     <= 2'b10;
      alu_q   <= ALU_ADD;
    end else begin
      state   <= nxt;
      fetch_q <= 1'b0;
      memw_q  <= 1'b0;
      br_q    <= 1'b0;
      pcw_q   <= 1'b0;
      regw_q  <= 1'b0;
      done_q  <= 1'b0;
      funct_q <= 1'b0;
      execr_q <= 1'b0;
      halt_q  <= 1'b0;
      adr_q   <= 1'b0;
      res_q   <= 2'b00;
      a_q     <= 2'b00;
      b_q     <= 2'b00;
      alu_q   <= ALU_ADD;
      case (nxt)
        S_FETCH: begin
          fetch_q <= 1'b1;
          res_q   <= 2'b10;
          b_q     <= 2'b10;
        end
        S_DECODE: begin
          a_q <= 2'b01;
          b_q <= 2'b01;
        end
        S_MEMADR: begin
          a_q <= 2'b10;
          b_q <= 2'b01;
        end
        S_MEMREAD: adr_q <= 1'b1;
        S_MEMWB: begin
          res_q  <= 2'b01;
          regw_q <= 1'b1;
          done_q <= 1'b1;
        end
        S_MEMWRITE: begin
          adr_q  <= 1'b1;
          memw_q <= 1'b1;
        end
        S_EXECR: begin
          a_q     <= 2'b10;
          funct_q <= 1'b1;
          execr_q <= 1'b1;
        end
        S_EXECI: begin
          a_q     <= 2'b10;
          b_q     <= 2'b01;
          funct_q <= 1'b1;
        end
        S_ALUWB: begin
          regw_q <= 1'b1;
          done_q <= 1'b1;
        end
        S_BEQ: begin
          a_q    <= 2'b10;
          alu_q  <= ALU_SUB;
          br_q   <= 1'b1;
          done_q <= 1'b1;
        end
        S_JAL: begin
          a_q   <= 2'b01;
          b_q   <= 2'b10;
          pcw_q <= 1'b1;
        end
        S_HALT:  halt_q <= 1'b1;
        default: halt_q <= 1'b1;
      endcase
    end
  end

  // strobes are held low for the whole reset assertion, not just after the edge
  assign ir_write    = rst_n & fetch_q & mem_ready;
  assign pc_write    = rst_n & ((fetch_q & mem_ready) | pcw_q | (br_q & taken));
  assign mem_write   = rst_n & memw_q & mem_ready;
  assign reg_write   = rst_n & regw_q;
  assign instr_done  = rst_n & (done_q | (memw_q & mem_ready));
  assign illegal_op  = halt_q;
  assign adr_src     = adr_q;
  assign result_src  = res_q;
  assign alu_src_a   = a_q;
  assign alu_src_b   = b_q;
  assign alu_control = funct_q ? funct_alu : alu_q;

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed cases plus random instruction stream
// with random memory stalls, checked against an instruction-level latency/strobe model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0;
  logic [2:0] funct3 = 3'b0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       instr_done, illegal_op;

  int total = 0;
  int bad = 0;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] kind_op(input int k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BR:    return 7'b1100011;
      default: return 7'b1101111;
    endcase
  endfunction

  // ALU op the instruction needs in its execute-step cycle
  function automatic logic [2:0] exp_alu(input int k, input logic [2:0] f3, input logic f7);
    if (k == K_BR) return 3'b001;
    if (k != K_R && k != K_I) return 3'b000;
    case (f3)
      3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // memory-ready schedule: fs fetch stalls, ms data stalls, random where not sampled
  function automatic logic mr(input int i, input int fs, input int ms, input bit memop);
    if (i < fs) return 1'b0;
    if (i == fs) return 1'b1;
    if (memop && i >= fs + 3 && i < fs + 3 + ms) return 1'b0;
    if (memop && i == fs + 3 + ms) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk({tag, " rst pc_write"}, pc_write, 0);
    chk({tag, " rst ir_write"}, ir_write, 0);
    chk({tag, " rst strobes"}, {mem_write, reg_write, instr_done}, 0);
    chk({tag, " rst illegal"}, illegal_op, 0);
    chk({tag, " rst selects"}, {adr_src, result_src, alu_src_a, alu_src_b}, 7'b0_10_00_10);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Called just after a clock edge with the DUT in FETCH; returns just after the edge following retire.
  task automatic run_instr(input string tag, input int k, input logic [2:0] f3, input logic f7,
                           input logic zr, input int fs, input int ms);
    bit   memop = (k == K_LW || k == K_SW);
    int   base, lat, n_ir, n_pc, n_reg, n_mem;
    int   e_pc, e_reg, e_mem;
    logic [2:0] alu_seen;
    logic [1:0] res_seen, imm_seen;
    logic pc_last;
    logic [1:0] e_imm;
    lat = 0; n_ir = 0; n_pc = 0; n_reg = 0; n_mem = 0;
    alu_seen = 3'bx; res_seen = 2'bx; imm_seen = 2'bx; pc_last = 1'bx;
    op = kind_op(k); funct3 = f3; funct7b5 = f7; zero = zr;
    case (k)
      K_LW:    begin base = 5; e_pc = 1; e_reg = 1; e_mem = 0; e_imm = 2'b00; end
      K_SW:    begin base = 4; e_pc = 1; e_reg = 0; e_mem = 1; e_imm = 2'b01; end
      K_R:     begin base = 4; e_pc = 1; e_reg = 1; e_mem = 0; e_imm = 2'b00; end
      K_I:     begin base = 4; e_pc = 1; e_reg = 1; e_mem = 0; e_imm = 2'b00; end
      K_BR:    begin base = 3; e_pc = 1 + int'(f3[0] ? ~zr : zr); e_reg = 0; e_mem = 0; e_imm = 2'b10; end
      default: begin base = 4; e_pc = 2; e_reg = 1; e_mem = 0; e_imm = 2'b11; end
    endcase
    for (int i = 0; i < 40; i++) begin
      mem_ready = mr(i, fs, ms, memop);
      @(negedge clk);
      n_ir  += int'(ir_write);
      n_pc  += int'(pc_write);
      n_reg += int'(reg_write);
      n_mem += int'(mem_write);
      if (i == fs + 2) alu_seen = alu_control;
      if (instr_done) begin
        lat = i + 1;
        res_seen = result_src;
        imm_seen = imm_src;
        pc_last = pc_write;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, lat, base + fs + (memop ? ms : 0));
    chk({tag, " ir_write count"}, n_ir, 1);
    chk({tag, " pc_write count"}, n_pc, e_pc);
    chk({tag, " reg_write count"}, n_reg, e_reg);
    chk({tag, " mem_write count"}, n_mem, e_mem);
    chk({tag, " alu_control"}, alu_seen, exp_alu(k, f3, f7));
    chk({tag, " result_src"}, res_seen, (k == K_LW) ? 2'b01 : 2'b00);
    chk({tag, " imm_src"}, imm_seen, e_imm);
    if (k == K_BR) chk({tag, " branch pc_write"}, pc_last, f3[0] ? ~zr : zr);
  endtask

  // opcode that must end in HALT: checks flag timing and 20 silent cycles
  task automatic run_halt(input string tag, input logic [6:0] o, input logic [2:0] f3);
    int n_strobe;
    n_strobe = 0;
    op = o; funct3 = f3; funct7b5 = 1'b0; zero = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk({tag, " illegal before decode"}, illegal_op, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " illegal in decode"}, illegal_op, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_strobe += int'(pc_write) + int'(ir_write) + int'(mem_write) + int'(reg_write) + int'(instr_done);
      if (i == 0) chk({tag, " illegal set"}, illegal_op, 1);
      @(posedge clk); #1;
    end
    chk({tag, " halt strobes"}, n_strobe, 0);
    chk({tag, " illegal sticky"}, illegal_op, 1);
  endtask

  initial begin
    int k, fs, ms;
    logic [2:0] f3;

    do_reset("init");
    mem_ready = 1'b1;
    op = 7'b0110011; funct3 = 3'b000;
    #1;
    chk("post-reset ir_write", ir_write, 1);
    chk("post-reset pc_write", pc_write, 1);
    chk("post-reset result_src", result_src, 2'b10);

    run_instr("lw stall2", K_LW, 3'b010, 1'b0, 1'b0, 0, 2);
    run_instr("sub", K_R, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("addi f7", K_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run_instr("beq taken", K_BR, 3'b000, 1'b0, 1'b1, 0, 0);
    run_instr("beq not", K_BR, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("jal", K_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    run_instr("sw stall", K_SW, 3'b010, 1'b0, 1'b0, 1, 3);
    run_instr("slt", K_R, 3'b010, 1'b0, 1'b0, 2, 0);

    run_halt("illegal", 7'b1111111, 3'b000);
    do_reset("clear");

`ifdef MC_BNE_EN
    run_instr("bne taken", K_BR, 3'b001, 1'b0, 1'b0, 0, 0);
    run_instr("bne not", K_BR, 3'b001, 1'b0, 1'b1, 0, 0);
`else
    run_halt("bne", 7'b1100011, 3'b001);
    do_reset("bne clear");
`endif

    // abandon an lw in MEMADR; the reset checks show no strobe escapes
    op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("mid");

    for (int n = 0; n < 40; n++) begin
      k  = int'($urandom_range(0, 5));
      f3 = 3'($urandom_range(0, 7));
      if (k == K_BR) f3 = 3'b000;
      fs = int'($urandom_range(0, 2));
      ms = int'($urandom_range(0, 2));
      run_instr($sformatf("rnd%0d k%0d", n, k), k, f3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), fs, ms);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
